// File: rtl/midi_note_rx.sv
// midi_note_rx: serial MIDI receiver that turns Note On / Note Off messages
// into the two 4-bit note codes of the melody synth (spk[3:0] voice 1,
// spk[7:4] voice 2).
//
// Pipeline: 2-flop synchroniser -> UART-style RX FSM -> status/data parser
// -> voice allocator.
// The RX FSM pulses rx_valid the cycle after the stop sample.
// The parser turns that byte into a one-cycle exec request on the next edge.
// The allocator updates spk and msg_strobe on the edge after that.
//
// Internal handshakes are single-cycle valid pulses with no ready: every
// stage accepts a pulse in the cycle it is presented. Nothing can stall,
// because a new byte needs ten bit times.
//
// Optional feature: define MIDI_RX_CHANNEL_FILTER_EN to accept Note On/Off
// only on channel MIDI_CH. Without it the receiver is omni.

module midi_note_rx #(
   parameter int CLKS_PER_BIT = 384,
   parameter int MIDI_CH      = 0
) (
   input  logic       clk12,
   input  logic       n_reset,
   input  logic       midi_in,
   output logic [7:0] spk,
   output logic       msg_strobe,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {P_WAIT_STATUS, P_WAIT_NOTE, P_WAIT_VEL} p_state_t;

   // ---------------- synchroniser ----------------
   logic [1:0] sync_q;
   logic       line;

   assign line = sync_q[1];

   // Two-flop synchroniser; the line idles high, so reset to 1.
   always_ff @(posedge clk12 or negedge n_reset) begin
      if (!n_reset) sync_q <= 2'b11;
      else          sync_q <= {sync_q[0], midi_in};
   end

   // ---------------- RX FSM ----------------
   rx_state_t     rx_state_q, rx_state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;

   // Bit timing: half a bit to the start-bit centre, then one full bit per sample.
   always_comb begin
      rx_state_d  = rx_state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!line) begin
               rx_state_d = RX_START;
               cnt_d      = '0;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d      = '0;
               bit_d      = 3'd0;
               rx_state_d = line ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {line, shift_q[7:1]};
               if (bit_q == 3'd7) rx_state_d = RX_STOP;
               else               bit_d      = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d      = '0;
               rx_state_d = RX_IDLE;
               if (line) rx_valid_d  = 1'b1;
               else      frame_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // RX FSM state and datapath registers.
   always_ff @(posedge clk12 or negedge n_reset) begin
      if (!n_reset) begin
         rx_state_q  <= RX_IDLE;
         cnt_q       <= '0;
         bit_q       <= 3'd0;
         shift_q     <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // ---------------- parser ----------------
   function automatic logic [3:0] note_code(input logic [6:0] n);
      case (n)
         7'd60:   note_code = 4'd1;
         7'd62:   note_code = 4'd2;
         7'd64:   note_code = 4'd3;
         7'd65:   note_code = 4'd4;
         7'd67:   note_code = 4'd5;
         7'd72:   note_code = 4'd6;
         7'd74:   note_code = 4'd7;
         7'd76:   note_code = 4'd8;
         7'd77:   note_code = 4'd9;
         7'd79:   note_code = 4'd10;
         default: note_code = 4'd0;
      endcase
   endfunction

   logic chan_ok;
`ifdef MIDI_RX_CHANNEL_FILTER_EN
   assign chan_ok = (shift_q[3:0] == 4'(MIDI_CH));
`else
   // Omni: the channel nibble is irrelevant, every channel is accepted.
   assign chan_ok = (shift_q[3:0] == 4'(MIDI_CH)) | 1'b1;
`endif

   p_state_t   p_state_q, p_state_d;
   logic       cmd_on_q, cmd_on_d;
   logic [6:0] note_q, note_d;
   logic       exec_q, exec_d;
   logic       exec_on_q, exec_on_d;
   logic [3:0] exec_code_q, exec_code_d;

   // Status / running-status parser; emits one exec pulse per velocity byte.
   always_comb begin
      p_state_d   = p_state_q;
      cmd_on_d    = cmd_on_q;
      note_d      = note_q;
      exec_d      = 1'b0;
      exec_on_d   = exec_on_q;
      exec_code_d = exec_code_q;
      if (frame_err_q) begin
         p_state_d = P_WAIT_STATUS;
      end else if (rx_valid_q) begin
         if (shift_q[7]) begin
            if (shift_q[7:3] == 5'b11111) begin
               // real-time byte: transparent to the message in progress
            end else if ((shift_q[7:5] == 3'b100) && chan_ok) begin
               cmd_on_d  = shift_q[4];
               p_state_d = P_WAIT_NOTE;
            end else begin
               p_state_d = P_WAIT_STATUS;
            end
         end else begin
            case (p_state_q)
               P_WAIT_NOTE: begin
                  note_d    = shift_q[6:0];
                  p_state_d = P_WAIT_VEL;
               end
               P_WAIT_VEL: begin
                  exec_code_d = note_code(note_q);
                  exec_d      = (note_code(note_q) != 4'd0);
                  exec_on_d   = cmd_on_q && (shift_q[6:0] != 7'd0);
                  p_state_d   = P_WAIT_NOTE;
               end
               default: p_state_d = P_WAIT_STATUS;
            endcase
         end
      end
   end

   // Parser FSM state and message registers.
   always_ff @(posedge clk12 or negedge n_reset) begin
      if (!n_reset) begin
         p_state_q   <= P_WAIT_STATUS;
         cmd_on_q    <= 1'b0;
         note_q      <= 7'd0;
         exec_q      <= 1'b0;
         exec_on_q   <= 1'b0;
         exec_code_q <= 4'd0;
      end else begin
         p_state_q   <= p_state_d;
         cmd_on_q    <= cmd_on_d;
         note_q      <= note_d;
         exec_q      <= exec_d;
         exec_on_q   <= exec_on_d;
         exec_code_q <= exec_code_d;
      end
   end

   // ---------------- voice allocator ----------------
   logic [3:0] v1_q, v1_d, v2_q, v2_d;
   logic       oldest_q, oldest_d;   // 0 = voice 1 is oldest, 1 = voice 2
   logic       strobe_q, strobe_d;

   // Two-voice allocation with oldest-voice stealing; strobe only on change.
   always_comb begin
      v1_d     = v1_q;
      v2_d     = v2_q;
      oldest_d = oldest_q;
      if (exec_q) begin
         if (exec_on_q) begin
            if ((v1_q == exec_code_q) || (v2_q == exec_code_q)) begin
               // already sounding
            end else if (v1_q == 4'd0) begin
               v1_d     = exec_code_q;
               oldest_d = 1'b1;
            end else if (v2_q == 4'd0) begin
               v2_d     = exec_code_q;
               oldest_d = 1'b0;
            end else if (!oldest_q) begin
               v1_d     = exec_code_q;
               oldest_d = 1'b1;
            end else begin
               v2_d     = exec_code_q;
               oldest_d = 1'b0;
            end
         end else begin
            if (v1_q == exec_code_q) v1_d = 4'd0;
            if (v2_q == exec_code_q) v2_d = 4'd0;
         end
      end
      strobe_d = ({v2_d, v1_d} != {v2_q, v1_q});
   end

   // Voice registers and change strobe.
   always_ff @(posedge clk12 or negedge n_reset) begin
      if (!n_reset) begin
         v1_q     <= 4'd0;
         v2_q     <= 4'd0;
         oldest_q <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         oldest_q <= oldest_d;
         strobe_q <= strobe_d;
      end
   end

   assign spk        = {v2_q, v1_q};
   assign msg_strobe = strobe_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_midi_note_rx.sv
// Testbench for midi_note_rx. A shortened bit time keeps the run short.
// Expected spk words are queued as messages are sent and popped by the
// strobe monitor.
module tb_midi_note_rx;

   localparam int P  = 32;
   localparam int CH = 2;

   logic       clk12   = 1'b0;
   logic       n_reset = 1'b0;
   logic       midi_in = 1'b1;
   logic [7:0] spk;
   logic       msg_strobe;
   logic       frame_err;

   int         checks     = 0;
   int         errors     = 0;
   int         cyc        = 0;
   int         start_cyc  = 0;
   int         strobe_cyc = 0;
   int         strobe_cnt = 0;
   int         ferr_cnt   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;

   midi_note_rx #(.CLKS_PER_BIT(P), .MIDI_CH(CH)) dut (
      .clk12      (clk12),
      .n_reset    (n_reset),
      .midi_in    (midi_in),
      .spk        (spk),
      .msg_strobe (msg_strobe),
      .frame_err  (frame_err)
   );

   // clock / cycle counter
   always #5 clk12 = ~clk12;
   always @(posedge clk12) cyc <= cyc + 1;

   // scoreboard: every strobe must match the next queued spk word
   always @(negedge clk12) begin
      if (n_reset === 1'b1) begin
         if (frame_err === 1'b1) ferr_cnt++;
         if (msg_strobe === 1'b1) begin
            strobe_cyc = cyc;
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: spk=%h, no update expected", spk);
            end else begin
               exp_v = exp_q.pop_front();
               if (spk !== exp_v) begin
                  errors++;
                  $display("FAIL spk_update: got %h expected %h", spk, exp_v);
               end
            end
         end
      end
   end

   // driver tasks
   task automatic send_frame(input logic [7:0] b, input bit good_stop);
      midi_in   = 1'b0;
      start_cyc = cyc;
      repeat (P) @(posedge clk12);
      for (int i = 0; i < 8; i++) begin
         midi_in = b[i];
         repeat (P) @(posedge clk12);
      end
      if (good_stop) begin
         midi_in = 1'b1;
         repeat (P) @(posedge clk12);
      end else begin
         midi_in = 1'b0;
         repeat (3 * P / 4) @(posedge clk12);
         midi_in = 1'b1;
         repeat (P / 4 + P) @(posedge clk12);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b1);
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send_byte(a);
      send_byte(b);
      send_byte(c);
   endtask

   task automatic reset_dut();
      #2 n_reset = 1'b0;
      midi_in = 1'b1;
      repeat (3) @(posedge clk12);
      #2 n_reset = 1'b1;
      exp_q.delete();
      repeat (3) @(posedge clk12);
   endtask

   task automatic end_check(input string name, input logic [7:0] exp_spk);
      repeat (20) @(posedge clk12);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_strobe: %0d updates outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (spk !== exp_spk) begin
         errors++;
         $display("FAIL %s_final_spk: got %h expected %h", name, spk, exp_spk);
      end
   endtask

   // tests
   task automatic test_reset();
      #2 n_reset = 1'b0;
      repeat (2) @(posedge clk12);
      #1;
      checks++;
      if (spk !== 8'h00) begin errors++; $display("FAIL reset_spk: got %h expected 00", spk); end
      checks++;
      if (msg_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", msg_strobe); end
      checks++;
      if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      reset_dut();
   endtask

   task automatic test_note_on();
      int n0;
      int delta;
      reset_dut();
      n0 = strobe_cnt;
      send_byte(8'h90);
      send_byte(8'h3C);
      exp_q.push_back(8'h01);
      send_byte(8'h64);
      end_check("note_on", 8'h01);
      checks++;
      if (strobe_cnt - n0 != 1) begin
         errors++;
         $display("FAIL note_on_strobe_count: got %0d expected 1", strobe_cnt - n0);
      end
      delta = strobe_cyc - start_cyc;
      checks++;
      if (delta < 9 * P + P / 2 + 1 || delta > 9 * P + P / 2 + 11) begin
         errors++;
         $display("FAIL note_on_latency: got %0d cycles expected about %0d", delta, 9 * P + P / 2 + 6);
      end
   endtask

   task automatic test_running_status();
      reset_dut();
      exp_q.push_back(8'h01);
      send3(8'h90, 8'h3C, 8'h40);
      exp_q.push_back(8'h61);
      send_byte(8'h48); send_byte(8'h40);
      exp_q.push_back(8'h6A);
      send_byte(8'h4F); send_byte(8'h40);
      // oldest is now voice 2
      exp_q.push_back(8'h2A);
      send_byte(8'h3E); send_byte(8'h40);
      // already sounding: no change
      send_byte(8'h3E); send_byte(8'h40);
      end_check("running_status", 8'h2A);
   endtask

   task automatic test_note_off();
      reset_dut();
      exp_q.push_back(8'h01);
      send3(8'h90, 8'h3C, 8'h40);
      exp_q.push_back(8'h61);
      send_byte(8'h48); send_byte(8'h40);
      exp_q.push_back(8'h01);
      send3(8'h80, 8'h48, 8'h00);
      exp_q.push_back(8'h00);
      send3(8'h90, 8'h3C, 8'h00);
      // off for a note nobody holds
      send3(8'h80, 8'h40, 8'h00);
      end_check("note_off", 8'h00);
   endtask

   task automatic test_realtime_unmapped();
      reset_dut();
      send_byte(8'h90);
      send_byte(8'h3C);
      send_byte(8'hF8);
      exp_q.push_back(8'h01);
      send_byte(8'h40);
      send_byte(8'h3D); send_byte(8'h40);
      exp_q.push_back(8'h31);
      send_byte(8'h40); send_byte(8'h40);
      // unsupported status kills running status
      send3(8'hA0, 8'h48, 8'h40);
      send_byte(8'h4C); send_byte(8'h40);
      end_check("realtime_unmapped", 8'h31);
   endtask

   task automatic test_frame_err();
      int f0;
      reset_dut();
      f0 = ferr_cnt;
      // a short glitch must not start a byte
      midi_in = 1'b0;
      repeat (P / 4) @(posedge clk12);
      midi_in = 1'b1;
      repeat (2 * P) @(posedge clk12);
      checks++;
      if (ferr_cnt != f0) begin
         errors++;
         $display("FAIL glitch_frame_err: got %0d pulses expected 0", ferr_cnt - f0);
      end
      send_byte(8'h90);
      send_frame(8'h3C, 1'b0);
      checks++;
      if (ferr_cnt - f0 != 1) begin
         errors++;
         $display("FAIL frame_err_pulse: got %0d pulses expected 1", ferr_cnt - f0);
      end
      send_byte(8'h3C); send_byte(8'h40);
      end_check("frame_err_ignored", 8'h00);
      exp_q.push_back(8'h01);
      send3(8'h90, 8'h3C, 8'h40);
      end_check("frame_err_recover", 8'h01);
   endtask

   task automatic test_channel();
      reset_dut();
`ifdef MIDI_RX_CHANNEL_FILTER_EN
      send3(8'h93, 8'h3C, 8'h40);
      exp_q.push_back(8'h06);
      send3(8'h92, 8'h48, 8'h40);
      end_check("channel_filter", 8'h06);
`else
      exp_q.push_back(8'h01);
      send3(8'h93, 8'h3C, 8'h40);
      exp_q.push_back(8'h61);
      send3(8'h92, 8'h48, 8'h40);
      end_check("channel_omni", 8'h61);
`endif
   endtask

   task automatic test_reset_mid_message();
      reset_dut();
      exp_q.push_back(8'h01);
      send3(8'h90, 8'h3C, 8'h40);
      end_check("pre_reset", 8'h01);
      send_byte(8'h90);
      send_byte(8'h3E);
      midi_in = 1'b0;
      repeat (4 * P) @(posedge clk12);
      #2 n_reset = 1'b0;
      #3;
      checks++;
      if (spk !== 8'h00) begin errors++; $display("FAIL async_reset_spk: got %h expected 00", spk); end
      midi_in = 1'b1;
      repeat (3) @(posedge clk12);
      #2 n_reset = 1'b1;
      repeat (3) @(posedge clk12);
      // parser restarted in WAIT_STATUS: these data bytes are ignored
      send_byte(8'h40);
      send_byte(8'h48); send_byte(8'h40);
      exp_q.push_back(8'h06);
      send3(8'h90, 8'h48, 8'h40);
      end_check("reset_mid_message", 8'h06);
   endtask

   task automatic test_back_to_back();
      reset_dut();
      exp_q.push_back(8'h01);
      send3(8'h90, 8'h3C, 8'h40);
      exp_q.push_back(8'h21);
      send_byte(8'h3E); send_byte(8'h40);
      exp_q.push_back(8'h23);
      send_byte(8'h40); send_byte(8'h40);
      end_check("back_to_back", 8'h23);
   endtask

   initial begin
      test_reset();
      test_note_on();
      test_running_status();
      test_note_off();
      test_realtime_unmapped();
      test_frame_err();
      test_channel();
      test_reset_mid_message();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
